// File: rtl/mem_uncache_unit_pkg.sv
// Shared types and constants for the uncached MEM-stage access unit.
package mem_uncache_unit_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } UncacheState_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int RESP_TIMEOUT_DEFAULT = 255;

  // Encoding 3 is illegal on the MEM side and is issued as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/mem_uncache_unit_if.sv
// Single-outstanding valid/ready uncached bus between the access unit and the bus interface.
interface mem_uncache_unit_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_wr;
  logic [31:0] bus_addr;
  logic [1:0]  bus_size;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_resp_valid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req_valid, bus_req_wr, bus_addr, bus_size, bus_wdata, bus_wstrb,
    input  bus_req_ready, bus_resp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_wr, bus_addr, bus_size, bus_wdata, bus_wstrb,
    output bus_req_ready, bus_resp_valid, bus_rdata
  );
endinterface

// File: rtl/mem_uncache_unit.sv
// Uncached load/store engine for the MEM stage: issues one bus access at a time,
// stalls the EXE->MEM register until completion and flags response timeouts.
module mem_uncache_unit
  import mem_uncache_unit_pkg::*;
#(
  parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_valid,
  input  logic        mem_req_wr,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        mem_flush,
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic        mem_rdata_valid,
  output logic        mem_bus_err,
  mem_uncache_unit_if.master bus
);

  localparam int CW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(RESP_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(RESP_TIMEOUT - 1);

  UncacheState_t state, state_nxt;
  logic          cancel;
  logic [CW-1:0] cnt;
  logic          forced_err;

  logic start, resp_hit, timeout, complete, cancel_now;

  assign start      = (state == IDLE) && mem_req_valid && !mem_flush;
  assign resp_hit   = (state == WAIT_RESP) && bus.bus_resp_valid;
  // The counter reaches RESP_TIMEOUT on the edge that ends the last allowed
  // WAIT_RESP cycle; a response in that same cycle takes priority.
  assign timeout    = (state == WAIT_RESP) && (cnt == CNT_LAST) && !bus.bus_resp_valid;
  assign complete   = resp_hit || timeout;
  assign cancel_now = cancel || mem_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = REQ;
      REQ:       if (bus.bus_req_ready) state_nxt = WAIT_RESP;
      WAIT_RESP: if (complete) state_nxt = cancel_now ? IDLE : DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.bus_req_valid = (state == REQ);
    mem_rdata_valid   = (state == DONE) && !bus.bus_req_wr;
    mem_bus_err       = (state == DONE) && forced_err;
    mem_stall         = mem_req_valid && !mem_flush && (state != DONE);
  end

  // A flushed access still finishes on the bus; cancel only discards its result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cancel     <= 1'b0;
      cnt        <= '0;
      forced_err <= 1'b0;
    end else begin
      if (start) begin
        cancel <= 1'b0;
      end else if ((state == REQ || state == WAIT_RESP) && mem_flush) begin
        cancel <= 1'b1;
      end
      if (state == REQ && bus.bus_req_ready) begin
        cnt <= '0;
      end else if (state == WAIT_RESP && cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
      if (complete) begin
        forced_err <= timeout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bus_req_wr <= 1'b0;
      bus.bus_addr   <= '0;
      bus.bus_size   <= '0;
      bus.bus_wdata  <= '0;
      bus.bus_wstrb  <= '0;
    end else if (start) begin
      bus.bus_req_wr <= mem_req_wr;
      bus.bus_addr   <= mem_addr;
      bus.bus_size   <= norm_size(mem_size);
      bus.bus_wdata  <= mem_wdata;
      bus.bus_wstrb  <= mem_wstrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rdata <= '0;
    end else if (complete && !bus.bus_req_wr && !cancel_now) begin
      mem_rdata <= resp_hit ? bus.bus_rdata : '0;
    end
  end

endmodule

// File: tb/tb_mem_uncache_unit.sv
// Scenario bench for mem_uncache_unit with a configurable bus responder and a completion scoreboard.
module tb_mem_uncache_unit;
  localparam int T = 4;

  logic        clk;
  logic        rst;
  logic        mem_req_valid, mem_req_wr, mem_flush;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic        mem_stall, mem_rdata_valid, mem_bus_err;
  logic [31:0] mem_rdata;

  mem_uncache_unit_if ifc();

  mem_uncache_unit #(.RESP_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_wr(mem_req_wr), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_flush(mem_flush),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .mem_bus_err(mem_bus_err), .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rsp_q[$];
  int          rdy_delay = 0;
  int          rsp_delay = 0;
  int          hs_count  = 0;
  bit          rsp_cancel = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] rdata_model = 32'h0;

  function automatic exp_t mk(input logic l, input logic e, input logic [31:0] d);
    exp_t r;
    r.load = l; r.err = e; r.data = d;
    return r;
  endfunction

  // Bus slave: ready after rdy_delay REQ cycles, response rsp_delay cycles after handshake.
  initial begin
    int rcnt, wcnt;
    bit pending;
    rcnt = 0; wcnt = 0; pending = 1'b0;
    ifc.bus_req_ready = 1'b0; ifc.bus_resp_valid = 1'b0; ifc.bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      ifc.bus_req_ready  = 1'b0;
      ifc.bus_resp_valid = 1'b0;
      if (rst || rsp_cancel) begin
        pending = 1'b0; rcnt = 0;
      end else if (ifc.bus_req_valid) begin
        pending = 1'b0;
        if (rcnt >= rdy_delay) begin
          ifc.bus_req_ready = 1'b1; rcnt = 0; pending = 1'b1; wcnt = 0; hs_count++;
        end else rcnt++;
      end else if (pending) begin
        if (wcnt >= rsp_delay && rsp_q.size() > 0) begin
          ifc.bus_resp_valid = 1'b1; ifc.bus_rdata = rsp_q.pop_front(); pending = 1'b0;
        end else wcnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] st);
    mem_req_valid = 1'b1; mem_req_wr = wr; mem_addr = a; mem_size = s; mem_wdata = d; mem_wstrb = st;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_req_valid = 1'b0; mem_req_wr = 1'b0; mem_flush = 1'b0;
    mem_addr = 32'h0; mem_size = 2'd0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    repeat (3) tick();
    #1;
    checks++;
    if ({mem_stall, mem_rdata_valid, mem_bus_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: stall/rv/err=%b expected 000", {mem_stall, mem_rdata_valid, mem_bus_err});
    end
    checks++;
    if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata); end
    checks++;
    if (ifc.bus_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", ifc.bus_req_valid); end
    checks++;
    if ({ifc.bus_req_wr, ifc.bus_addr, ifc.bus_size, ifc.bus_wdata, ifc.bus_wstrb} !== 71'h0) begin
      errors++; $display("FAIL reset_payload: addr=%h wdata=%h expected all zero", ifc.bus_addr, ifc.bus_wdata);
    end
    tick(); rst = 1'b0;
  endtask

  task automatic test_load_word();
    exp_t e;
    rdy_delay = 0; rsp_delay = 0; rsp_q.push_back(32'hDEAD_BEEF);
    tick(); issue(1'b0, 32'h1FD0_F000, 2'd2, 32'h0, 4'hF); sb.push_back(mk(1'b1, 1'b0, 32'hDEAD_BEEF));
    #1;
    checks++;
    if (mem_stall !== 1'b1 || ifc.bus_req_valid !== 1'b0) begin
      errors++; $display("FAIL load_cyc0: stall=%b req_valid=%b expected 1 0", mem_stall, ifc.bus_req_valid);
    end
    for (int c = 1; c <= 3; c++) begin
      tick(); #1;
      checks++;
      if (mem_stall !== (c < 3)) begin errors++; $display("FAIL load_stall c%0d: got %b expected %b", c, mem_stall, c < 3); end
      checks++;
      if (ifc.bus_req_valid !== (c == 1)) begin errors++; $display("FAIL load_req_valid c%0d: got %b expected %b", c, ifc.bus_req_valid, c == 1); end
      checks++;
      if (mem_rdata_valid !== (c == 3)) begin errors++; $display("FAIL load_rv c%0d: got %b expected %b", c, mem_rdata_valid, c == 3); end
      if (c == 1) begin
        checks++;
        if ({ifc.bus_req_wr, ifc.bus_addr, ifc.bus_size} !== {1'b0, 32'h1FD0_F000, 2'd2}) begin
          errors++; $display("FAIL load_payload: wr=%b addr=%h size=%0d expected 0 1fd0f000 2", ifc.bus_req_wr, ifc.bus_addr, ifc.bus_size);
        end
      end
      if (mem_rdata_valid && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (mem_rdata !== e.data || mem_bus_err !== e.err) begin
          errors++; $display("FAIL load_data: got %h err=%b expected %h err=%b", mem_rdata, mem_bus_err, e.data, e.err);
        end
      end
    end
    rdata_model = 32'hDEAD_BEEF;
    tick(); mem_req_valid = 1'b0; #1;
    checks++;
    if (mem_rdata_valid !== 1'b0) begin errors++; $display("FAIL load_rv_after: got %b expected 0", mem_rdata_valid); end
  endtask

  task automatic test_store_stall();
    int req_cyc;
    bit done;
    req_cyc = 0; done = 1'b0;
    rdy_delay = 5; rsp_delay = 1; rsp_q.push_back(32'hFFFF_FFFF);
    tick(); issue(1'b1, 32'h1FD0_0101, 2'd0, 32'h0000_5A00, 4'b0010);
    for (int c = 1; c <= 20 && !done; c++) begin
      tick(); #1;
      if (ifc.bus_req_valid) begin
        req_cyc++;
        checks++;
        if ({ifc.bus_req_wr, ifc.bus_addr, ifc.bus_size, ifc.bus_wdata, ifc.bus_wstrb} !==
            {1'b1, 32'h1FD0_0101, 2'd0, 32'h0000_5A00, 4'b0010}) begin
          errors++; $display("FAIL store_payload c%0d: addr=%h wdata=%h wstrb=%b expected 1fd00101 00005a00 0010",
                             c, ifc.bus_addr, ifc.bus_wdata, ifc.bus_wstrb);
        end
      end
      checks++;
      if (mem_rdata_valid !== 1'b0 || mem_bus_err !== 1'b0) begin
        errors++; $display("FAIL store_pulse c%0d: rv=%b err=%b expected 0 0", c, mem_rdata_valid, mem_bus_err);
      end
      if (!mem_stall) done = 1'b1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL store_done: no DONE within 20 cycles, expected completion"); end
    checks++;
    if (req_cyc != 6) begin errors++; $display("FAIL store_req_cycles: got %0d expected 6", req_cyc); end
    checks++;
    if (mem_rdata !== rdata_model) begin errors++; $display("FAIL store_rdata_hold: got %h expected %h", mem_rdata, rdata_model); end
    tick(); mem_req_valid = 1'b0; rdy_delay = 0;
  endtask

  task automatic test_flush_load();
    exp_t e;
    bit done;
    done = 1'b0;
    rdy_delay = 0; rsp_delay = 2; rsp_q.push_back(32'h1234_5678); rsp_q.push_back(32'hCAFE_F00D);
    tick(); issue(1'b0, 32'h1FD0_F004, 2'd2, 32'h0, 4'hF);
    tick();
    tick(); mem_flush = 1'b1; #1;
    checks++;
    if (mem_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", mem_stall); end
    tick(); mem_flush = 1'b0;
    issue(1'b0, 32'h1FD0_F008, 2'd2, 32'h0, 4'hF); sb.push_back(mk(1'b1, 1'b0, 32'hCAFE_F00D));
    for (int c = 3; c <= 30 && !done; c++) begin
      if (c > 3) tick();
      #1;
      if (mem_rdata_valid) begin
        done = 1'b1;
        e = sb.pop_front();
        checks++;
        if (mem_rdata !== e.data || mem_bus_err !== e.err) begin
          errors++; $display("FAIL flush_next_data: got %h err=%b expected %h err=%b", mem_rdata, mem_bus_err, e.data, e.err);
        end
      end else begin
        checks++;
        if (mem_stall !== 1'b1 || mem_bus_err !== 1'b0 || mem_rdata !== rdata_model) begin
          errors++; $display("FAIL flush_drain c%0d: stall=%b err=%b rdata=%h expected 1 0 %h",
                             c, mem_stall, mem_bus_err, mem_rdata, rdata_model);
        end
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL flush_next_done: no completion within bound, expected one"); end
    rdata_model = 32'hCAFE_F00D;
    tick(); mem_req_valid = 1'b0;
  endtask

  // Shared by the forced-timeout and response-on-timeout-cycle scenarios.
  task automatic test_timeout_case(input bit respond, input logic [31:0] rd, input string tag);
    exp_t e;
    int done_c, err_pulses;
    done_c = -1; err_pulses = 0;
    rdy_delay = 0; rsp_delay = T - 1;
    if (respond) rsp_q.push_back(rd);
    tick(); issue(1'b0, 32'h1FD0_F00C, 2'd2, 32'h0, 4'hF);
    sb.push_back(mk(1'b1, !respond, respond ? rd : 32'h0));
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 7) mem_req_valid = 1'b0;
      #1;
      if (mem_bus_err) err_pulses++;
      if ((mem_rdata_valid || mem_bus_err) && done_c < 0) begin
        done_c = c;
        e = sb.pop_front();
        checks++;
        if ({mem_rdata_valid, mem_bus_err, mem_rdata} !== {1'b1, e.err, e.data}) begin
          errors++; $display("FAIL %s_result: rv=%b err=%b rdata=%h expected 1 %b %h",
                             tag, mem_rdata_valid, mem_bus_err, mem_rdata, e.err, e.data);
        end
      end
    end
    checks++;
    if (done_c != 6) begin errors++; $display("FAIL %s_cycle: done at %0d expected 6", tag, done_c); end
    checks++;
    if (err_pulses != (respond ? 0 : 1)) begin
      errors++; $display("FAIL %s_err_pulses: got %0d expected %0d", tag, err_pulses, respond ? 0 : 1);
    end
    rdata_model = respond ? rd : 32'h0;
    rsp_cancel = 1'b1; tick(); rsp_cancel = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    int done_c;
    done_c = -1;
    rdy_delay = 0; rsp_delay = 10; rsp_q.push_back(32'h55AA_55AA);
    tick(); issue(1'b0, 32'h1FD0_F010, 2'd2, 32'h0, 4'hF);
    tick(); tick(); tick();
    mem_req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_stall, mem_rdata_valid, mem_bus_err, ifc.bus_req_valid} !== 4'b0000 || mem_rdata !== 32'h0) begin
      errors++; $display("FAIL areset_outputs: stall/rv/err/reqv=%b rdata=%h expected 0000 0",
                         {mem_stall, mem_rdata_valid, mem_bus_err, ifc.bus_req_valid}, mem_rdata);
    end
    checks++;
    if ({ifc.bus_req_wr, ifc.bus_addr, ifc.bus_size, ifc.bus_wdata, ifc.bus_wstrb} !== 71'h0) begin
      errors++; $display("FAIL areset_payload: addr=%h expected 0", ifc.bus_addr);
    end
    tick(); tick();
    rsp_q.delete(); rst = 1'b0;
    rsp_delay = 0; rsp_q.push_back(32'h0F0F_F0F0);
    tick(); issue(1'b0, 32'h1FD0_F014, 2'd2, 32'h0, 4'hF); sb.push_back(mk(1'b1, 1'b0, 32'h0F0F_F0F0));
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 4) mem_req_valid = 1'b0;
      #1;
      if (mem_rdata_valid && done_c < 0) begin
        done_c = c;
        e = sb.pop_front();
        checks++;
        if (mem_rdata !== e.data || mem_bus_err !== e.err) begin
          errors++; $display("FAIL areset_next_data: got %h err=%b expected %h err=%b", mem_rdata, mem_bus_err, e.data, e.err);
        end
      end
    end
    checks++;
    if (done_c != 3) begin errors++; $display("FAIL areset_next_cycle: done at %0d expected 3", done_c); end
    rdata_model = 32'h0F0F_F0F0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int hs0;
    hs0 = hs_count;
    rdy_delay = 0; rsp_delay = 0; rsp_q.push_back(32'h1111_2222); rsp_q.push_back(32'h3333_4444);
    tick(); issue(1'b0, 32'h1FD0_F020, 2'd2, 32'h0, 4'hF); sb.push_back(mk(1'b1, 1'b0, 32'h1111_2222));
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 4) begin
        issue(1'b0, 32'h1FD0_F024, 2'd3, 32'h0, 4'hF); sb.push_back(mk(1'b1, 1'b0, 32'h3333_4444));
      end
      if (c == 8) mem_req_valid = 1'b0;
      #1;
      if (c == 4) begin
        checks++;
        if (ifc.bus_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_reissue: req_valid=%b expected 0", ifc.bus_req_valid); end
      end
      if (c == 5) begin
        checks++;
        if ({ifc.bus_req_valid, ifc.bus_addr, ifc.bus_size} !== {1'b1, 32'h1FD0_F024, 2'd2}) begin
          errors++; $display("FAIL b2b_second_req: valid=%b addr=%h size=%0d expected 1 1fd0f024 2",
                             ifc.bus_req_valid, ifc.bus_addr, ifc.bus_size);
        end
      end
      checks++;
      if (mem_rdata_valid !== (c == 3 || c == 7)) begin
        errors++; $display("FAIL b2b_rv c%0d: got %b expected %b", c, mem_rdata_valid, (c == 3 || c == 7));
      end
      if (mem_rdata_valid && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (mem_rdata !== e.data) begin errors++; $display("FAIL b2b_data c%0d: got %h expected %h", c, mem_rdata, e.data); end
      end
    end
    tick();
    checks++;
    if (hs_count - hs0 != 2) begin errors++; $display("FAIL b2b_handshakes: got %0d expected 2", hs_count - hs0); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_word();
    test_store_stall();
    test_flush_load();
    test_timeout_case(1'b0, 32'h0, "timeout");
    test_back_to_back();
    test_timeout_case(1'b1, 32'h7777_1111, "resp_at_timeout");
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_uncache_unit.md
# mem_uncache_unit

Executes uncached loads and stores issued from the MEM stage over a single-outstanding valid/ready bus, and generates the stall that holds the EXE→MEM pipeline register (drives its write-enable low) until the access completes. It sits between the MEM stage and the uncached port of the data-side bus interface. It returns raw 32-bit read data to the MEM stage. A response watchdog reports a bus error when no response arrives.

## Interface
- RESP_TIMEOUT, 255: maximum cycles spent in WAIT_RESP before forcing an error completion; must be ≥1.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- mem_req_valid  in  1  MEM-stage instruction is an uncached load/store.
- mem_req_wr  in  1  1 = store, 0 = load.
- mem_addr  in  32  physical address, passed to the bus unmodified.
- mem_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and is treated as word.
- mem_wdata  in  32  store data, already lane-aligned.
- mem_wstrb  in  4  byte write enables.
- mem_flush  in  1  MEM-stage flush (exception or redirect).
- mem_stall  out  1  hold request; the pipeline deasserts MEM_Wr while this is 1.
- mem_rdata  out  32  captured load data; holds its value until the next capture.
- mem_rdata_valid  out  1  one-cycle pulse on load completion.
- mem_bus_err  out  1  one-cycle pulse when completion was forced by timeout.
- bus_req_valid / bus_req_ready  out/in  1  request handshake.
- bus_req_wr, bus_addr[31:0], bus_size[1:0], bus_wdata[31:0], bus_wstrb[3:0]  out  request payload (registered).
- bus_resp_valid  in  1  response present; it is always accepted.
- bus_rdata  in  32  response data; ignored for stores.

## Operation
- FSM states: IDLE, REQ, WAIT_RESP, DONE. A `cancel` flag is kept alongside the FSM.
- **IDLE**
  - When mem_req_valid=1 and mem_flush=0: latch the payload into the bus_* registers, clear `cancel`, go to REQ.
- **REQ**
  - bus_req_valid=1.
  - The payload and valid stay stable until bus_req_ready=1. A flush never retracts valid.
  - On handshake: go to WAIT_RESP and clear the timeout counter.
- **WAIT_RESP**
  - The timeout counter increments every cycle.
  - On bus_resp_valid: capture bus_rdata into mem_rdata if this is a load and not cancelled.
  - When the counter reaches RESP_TIMEOUT: force completion. Capture 0 if this is a load and not cancelled, and raise the error.
  - At completion, if `cancel`=1: go to IDLE with no pulses. Otherwise go to DONE.
- **DONE**
  - Lasts one cycle, then returns to IDLE.
  - mem_rdata_valid=1 for a load; mem_bus_err=1 if the completion was forced.
- **Flush:** mem_flush=1 while in REQ or WAIT_RESP sets `cancel`. The transaction finishes on the bus and its result is discarded.
- **Stall:** mem_stall = mem_req_valid & ~mem_flush & (state≠DONE).
  - The stall stays high while a cancelled transaction drains and a new request is waiting.
  - mem_stall is combinational from the inputs and state.
- Simultaneous bus_resp_valid and timeout in the same cycle: the response wins, and there is no error.
- Timeout counter width: $clog2(RESP_TIMEOUT+1); the counter saturates.

## Timing
- Reset values:
  - state=IDLE, cancel=0, counter=0.
  - mem_rdata=0, all bus_* registers=0.
  - mem_stall=0, mem_rdata_valid=0, mem_bus_err=0.
- Reset asserted mid-transaction returns the block to IDLE immediately. The bus side must be reset together with this block.
- Minimum latency, with ready and response each returned on their first opportunity:
  - cycle 0: IDLE, request seen.
  - cycle 1: REQ, handshake.
  - cycle 2: WAIT_RESP, response.
  - cycle 3: DONE.
  - mem_stall is high in cycles 0–2 and low in cycle 3. The MEM register loads the next instruction at the end of cycle 3.
- A new request is seen in IDLE no earlier than cycle 4. There is no double issue because DONE never samples mem_req_valid.
- bus_* outputs are registered. mem_rdata is updated at the WAIT_RESP exit edge and is valid during DONE.

## Structure
- Shared package:
  - the state enum `UncacheState_t`;
  - the size encoding constants SIZE_BYTE/HALF/WORD;
  - the RESP_TIMEOUT default constant.
- A single module; no sub-module is warranted. The timeout counter is inline.

## Test plan
- Load word at 0x1FD0_F000, ready at the first REQ cycle, response 0xDEAD_BEEF one cycle later → mem_rdata_valid pulses in cycle 3, mem_rdata=0xDEAD_BEEF, mem_stall high in cycles 0–2.
- Store byte, wdata=0x0000_5A00, wstrb=4'b0010, ready held low for 5 cycles → bus payload stable throughout, then DONE with no rdata_valid and mem_rdata unchanged.
- Load with mem_flush pulsed in WAIT_RESP, response 0x1234_5678 → no rdata_valid, mem_rdata keeps its previous value, FSM back in IDLE.
- RESP_TIMEOUT=4, no response → mem_bus_err pulses once, mem_rdata=0, a following request is accepted normally.
- Response arriving on exactly the timeout cycle → mem_bus_err=0 and the data is captured.
- rst asserted in WAIT_RESP → all outputs 0 asynchronously, state IDLE, next load completes correctly.
